// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types and elaboration helpers for the N-port round-robin memory arbiter.
// Default widths can be overridden by defining the MEM_* macros ahead of this file.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif

package mem_arbiter_rr_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WDATA = 1'b1
    } arb_state_t;

    // Index width for an n-entry selector, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_bits(input int max_count);
        return (max_count > 0) ? $clog2(max_count + 1) : 1;
    endfunction

    // The tag must be wide enough to carry every port index.
    function automatic bit tag_width_ok(input int num_ports, input int tag_bits);
        return (tag_bits >= 31) || ((32'd1 << tag_bits) >= num_ports);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester after rr_last,
// wrapping modulo NUM_PORTS.
module rr_arbiter #(
    parameter  int NUM_PORTS = 2,
    localparam int PORT_BITS = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] eligible,
    input  logic [PORT_BITS-1:0] rr_last,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PORT_BITS-1:0] winner,
    output logic                 any
);

    logic [PORT_BITS-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = PORT_BITS'((int'(rr_last) + k) % NUM_PORTS);
            if (!any && eligible[idx]) begin
                any        = 1'b1;
                winner     = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port memory arbiter: round-robin request grant, atomic write-data bursts,
// per-port read throttling and tag-routed read response strobes.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | arbitrating; reads may be granted back-to-back every cycle
// ST_WDATA | forwarding WRITE_BEATS data beats from the write owner only
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_BITS       = `MEM_ADDR_BITS,
    parameter int TAG_BITS        = `MEM_TAG_BITS,
    parameter int DATA_BITS       = `MEM_DATA_BITS,
    parameter int WRITE_BEATS     = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS-1:0]             req_rw,
    input  logic [NUM_PORTS*ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_PORTS-1:0]             req_data_valid,
    output logic [NUM_PORTS-1:0]             req_data_ready,
    input  logic [NUM_PORTS*DATA_BITS-1:0]   req_data_bits,
    input  logic [NUM_PORTS*DATA_BITS/8-1:0] req_data_mask,
    output logic [NUM_PORTS-1:0]             resp_valid,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic                             mem_req_rw,
    output logic [ADDR_BITS-1:0]             mem_req_addr,
    output logic [TAG_BITS-1:0]              mem_req_tag,
    output logic                             mem_req_data_valid,
    input  logic                             mem_req_data_ready,
    output logic [DATA_BITS-1:0]             mem_req_data_bits,
    output logic [DATA_BITS/8-1:0]           mem_req_data_mask,
    input  logic                             mem_resp_valid,
    input  logic [TAG_BITS-1:0]              mem_resp_tag
);

    localparam int  PORT_BITS = idx_bits(NUM_PORTS);
    localparam int  BEAT_BITS = idx_bits(WRITE_BEATS);
    localparam int  CNT_BITS  = cnt_bits(MAX_OUTSTANDING);
    localparam int  MASK_BITS = DATA_BITS / 8;
    localparam bit  TAG_OK    = tag_width_ok(NUM_PORTS, TAG_BITS);

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(WRITE_BEATS - 1);
    localparam logic [CNT_BITS-1:0]  CNT_MAX   = CNT_BITS'(MAX_OUTSTANDING);

    arb_state_t           state, state_nxt;
    logic [PORT_BITS-1:0] rr_last;
    logic [PORT_BITS-1:0] owner;
    logic [PORT_BITS-1:0] winner;
    logic [BEAT_BITS-1:0] beat_cnt;
    logic [CNT_BITS-1:0]  out_cnt [NUM_PORTS];

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] rd_inc;
    logic                 any_elig;
    logic                 in_idle;
    logic                 in_wdata;
    logic                 req_hs;
    logic                 data_hs;

    // Reads are held back once a port has MAX_OUTSTANDING in flight; writes never are.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = req_valid[i] && (req_rw[i] || (out_cnt[i] < CNT_MAX));
        end
    end

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter (
        .eligible (eligible),
        .rr_last  (rr_last),
        .grant    (grant),
        .winner   (winner),
        .any      (any_elig)
    );

    // Gating with reset keeps any handshake from completing in the reset cycle.
    assign in_idle  = !reset && (state == ST_IDLE);
    assign in_wdata = !reset && (state == ST_WDATA);

    assign mem_req_valid = in_idle && any_elig;
    assign mem_req_rw    = req_rw[winner];
    assign mem_req_addr  = req_addr[winner*ADDR_BITS +: ADDR_BITS];
    assign mem_req_tag   = TAG_BITS'(winner);
    assign req_ready     = {NUM_PORTS{mem_req_valid && mem_req_ready}} & grant;
    assign req_hs        = mem_req_valid && mem_req_ready;

    assign mem_req_data_valid = in_wdata && req_data_valid[owner];
    assign mem_req_data_bits  = req_data_bits[owner*DATA_BITS +: DATA_BITS];
    assign mem_req_data_mask  = req_data_mask[owner*MASK_BITS +: MASK_BITS];
    assign data_hs            = mem_req_data_valid && mem_req_data_ready;

    always_comb begin
        req_data_ready = '0;
        if (in_wdata) begin
            req_data_ready[owner] = mem_req_data_ready;
        end
    end

    // Tags at or above NUM_PORTS match no port and are silently dropped.
    always_comb begin
        rd_inc     = '0;
        resp_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_inc[i]     = req_hs && !mem_req_rw && (winner == PORT_BITS'(i));
            resp_valid[i] = TAG_OK && mem_resp_valid && (mem_resp_tag == TAG_BITS'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_hs && mem_req_rw) begin
                    state_nxt = ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (data_hs && (beat_cnt == LAST_BEAT)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            rr_last  <= PORT_BITS'(NUM_PORTS - 1);
            owner    <= '0;
            beat_cnt <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                out_cnt[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (req_hs) begin
                rr_last <= winner;
                if (mem_req_rw) begin
                    owner    <= winner;
                    beat_cnt <= '0;
                end
            end
            if (data_hs) begin
                beat_cnt <= beat_cnt + BEAT_BITS'(1);
            end
            // Grant and response on the same port cancel; a stray response at zero saturates.
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (rd_inc[i] && !resp_valid[i]) begin
                    out_cnt[i] <= out_cnt[i] + CNT_BITS'(1);
                end else if (!rd_inc[i] && resp_valid[i] && (out_cnt[i] != '0)) begin
                    out_cnt[i] <= out_cnt[i] - CNT_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_mem_arbiter_rr;

    localparam int NP = 3;
    localparam int AB = 16;
    localparam int TB = 2;
    localparam int DB = 16;
    localparam int MB = DB / 8;
    localparam int WB = 4;
    localparam int MO = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    req_valid, req_ready, req_rw, req_data_valid, req_data_ready, resp_valid;
    logic [NP*AB-1:0] req_addr;
    logic [NP*DB-1:0] req_data_bits;
    logic [NP*MB-1:0] req_data_mask;
    logic             mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AB-1:0]    mem_req_addr;
    logic [TB-1:0]    mem_req_tag;
    logic             mem_req_data_valid, mem_req_data_ready;
    logic [DB-1:0]    mem_req_data_bits;
    logic [MB-1:0]    mem_req_data_mask;
    logic             mem_resp_valid;
    logic [TB-1:0]    mem_resp_tag;

    mem_arbiter_rr #(
        .NUM_PORTS       (NP),
        .ADDR_BITS       (AB),
        .TAG_BITS        (TB),
        .DATA_BITS       (DB),
        .WRITE_BEATS     (WB),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_rw             (req_rw),
        .req_addr           (req_addr),
        .req_data_valid     (req_data_valid),
        .req_data_ready     (req_data_ready),
        .req_data_bits      (req_data_bits),
        .req_data_mask      (req_data_mask),
        .resp_valid         (resp_valid),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_tag       (mem_resp_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: last granted port, burst progress, reads in flight per port.
    int m_last = NP - 1;
    bit m_busy = 1'b0;
    int m_owner = 0;
    int m_left = 0;
    int m_out [NP];

    initial begin
        for (int i = 0; i < NP; i++) m_out[i] = 0;
    end

    always @(negedge clk) begin : compare
        int          w;
        int          p;
        int          t;
        bit          found;
        logic [NP-1:0] e_rdy;
        logic [NP-1:0] e_drdy;
        logic [NP-1:0] e_resp;

        e_resp = '0;
        if (mem_resp_valid && (int'(mem_resp_tag) < NP)) e_resp[mem_resp_tag] = 1'b1;
        chk("m_resp_valid", resp_valid, e_resp);

        if (reset) begin
            chk("m_rst_req_valid", mem_req_valid, 1'b0);
            chk("m_rst_req_ready", req_ready, '0);
            chk("m_rst_data_valid", mem_req_data_valid, 1'b0);
            chk("m_rst_data_ready", req_data_ready, '0);
            m_last  = NP - 1;
            m_busy  = 1'b0;
            m_owner = 0;
            m_left  = 0;
            for (int i = 0; i < NP; i++) m_out[i] = 0;
        end else if (!m_busy) begin
            found = 1'b0;
            w = 0;
            for (int k = 1; k <= NP; k++) begin
                p = (m_last + k) % NP;
                if (!found && req_valid[p] && (req_rw[p] || m_out[p] < MO)) begin
                    found = 1'b1;
                    w = p;
                end
            end
            e_rdy = '0;
            if (found && mem_req_ready) e_rdy[w] = 1'b1;
            chk("m_req_valid", mem_req_valid, found);
            chk("m_req_ready", req_ready, e_rdy);
            chk("m_idle_data_valid", mem_req_data_valid, 1'b0);
            chk("m_idle_data_ready", req_data_ready, '0);
            if (found) begin
                chk("m_req_rw", mem_req_rw, req_rw[w]);
                chk("m_req_addr", mem_req_addr, req_addr[w*AB +: AB]);
                chk("m_req_tag", mem_req_tag, w);
            end
            if (found && mem_req_ready) begin
                m_last = w;
                if (req_rw[w]) begin
                    m_busy  = 1'b1;
                    m_owner = w;
                    m_left  = WB;
                end else begin
                    m_out[w]++;
                end
            end
        end else begin
            e_drdy = '0;
            if (mem_req_data_ready) e_drdy[m_owner] = 1'b1;
            chk("m_burst_req_valid", mem_req_valid, 1'b0);
            chk("m_burst_req_ready", req_ready, '0);
            chk("m_data_valid", mem_req_data_valid, req_data_valid[m_owner]);
            chk("m_data_ready", req_data_ready, e_drdy);
            if (req_data_valid[m_owner]) begin
                chk("m_data_bits", mem_req_data_bits, req_data_bits[m_owner*DB +: DB]);
                chk("m_data_mask", mem_req_data_mask, req_data_mask[m_owner*MB +: MB]);
                if (mem_req_data_ready) begin
                    m_left--;
                    if (m_left == 0) m_busy = 1'b0;
                end
            end
        end

        if (!reset && (e_resp != '0)) begin
            t = int'(mem_resp_tag);
            if (m_out[t] > 0) m_out[t]--;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid          = '0;
        req_rw             = '0;
        req_addr           = '0;
        req_data_valid     = '0;
        req_data_bits      = '0;
        req_data_mask      = '0;
        mem_req_ready      = 1'b0;
        mem_req_data_ready = 1'b0;
        mem_resp_valid     = 1'b0;
        mem_resp_tag       = '0;
    endtask

    task automatic respond(input int tag);
        mem_resp_valid = 1'b1;
        mem_resp_tag   = TB'(tag);
        step();
        mem_resp_valid = 1'b0;
    endtask

    logic [DB-1:0] beat_data [WB];
    logic [MB-1:0] beat_mask [WB];

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) step();

        // Reset state
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_req_ready", req_ready, 3'b000);
        step();

        // Two readers alternate, starting at port 0
        req_valid = 3'b011;
        req_addr[0*AB +: AB] = 16'h1000;
        req_addr[1*AB +: AB] = 16'h2000;
        mem_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_tag", mem_req_tag, (k % 2 == 0) ? 2'd0 : 2'd1);
            chk("alt_ready", req_ready, (k % 2 == 0) ? 3'b001 : 3'b010);
            step();
        end
        req_valid = '0;
        respond(0); respond(1); respond(0); respond(1);

        // Port 0 fills its read budget; port 1 still served
        req_valid = 3'b001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("thr_fill", req_ready, 3'b001);
            step();
        end
        req_valid = 3'b011;
        @(negedge clk);
        chk("thr_stall", req_ready, 3'b010);
        step();
        req_valid = 3'b001;
        mem_resp_valid = 1'b1;
        mem_resp_tag = 2'd0;
        @(negedge clk);
        chk("thr_resp_cycle", req_ready, 3'b000);
        chk("thr_resp_valid", resp_valid, 3'b001);
        step();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("thr_regrant", req_ready, 3'b001);
        step();

        // Port 1 grant and response in one cycle leave its count at 1
        req_valid = 3'b010;
        mem_resp_valid = 1'b1;
        mem_resp_tag = 2'd1;
        @(negedge clk);
        chk("same_ready", req_ready, 3'b010);
        chk("same_resp", resp_valid, 3'b010);
        step();
        mem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("same_fill", req_ready, 3'b010);
            step();
        end
        @(negedge clk);
        chk("same_full", req_ready, 3'b000);
        step();

        // Out-of-range tag is dropped
        mem_resp_valid = 1'b1;
        mem_resp_tag = 2'd3;
        @(negedge clk);
        chk("bad_tag_resp", resp_valid, 3'b000);
        step();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("bad_tag_keep", req_ready, 3'b000);
        step();
        req_valid = '0;
        for (int k = 0; k < 4; k++) respond(0);
        for (int k = 0; k < 4; k++) respond(1);

        // Port 1 write burst while port 2 waits with a read
        req_valid = 3'b010;
        req_rw = 3'b010;
        req_addr[1*AB +: AB] = 16'h0040;
        @(negedge clk);
        chk("wr_ready", req_ready, 3'b010);
        chk("wr_rw", mem_req_rw, 1'b1);
        chk("wr_addr", mem_req_addr, 16'h0040);
        chk("wr_tag", mem_req_tag, 2'd1);
        step();
        beat_data[0] = 16'hD000; beat_mask[0] = 2'b11;
        beat_data[1] = 16'hD001; beat_mask[1] = 2'b01;
        beat_data[2] = 16'hD002; beat_mask[2] = 2'b10;
        beat_data[3] = 16'hD003; beat_mask[3] = 2'b11;
        req_valid = 3'b100;
        req_rw = 3'b000;
        req_data_valid = 3'b010;
        mem_req_data_ready = 1'b1;
        for (int b = 0; b < WB; b++) begin
            req_data_bits[1*DB +: DB] = beat_data[b];
            req_data_mask[1*MB +: MB] = beat_mask[b];
            if (b == 2) begin
                mem_req_data_ready = 1'b0;
                @(negedge clk);
                chk("wr_stall_dready", req_data_ready, 3'b000);
                chk("wr_stall_grant", req_ready, 3'b000);
                step();
                mem_req_data_ready = 1'b1;
            end
            @(negedge clk);
            chk("wr_bits", mem_req_data_bits, beat_data[b]);
            chk("wr_mask", mem_req_data_mask, beat_mask[b]);
            chk("wr_dready", req_data_ready, 3'b010);
            chk("wr_hold_grant", req_ready, 3'b000);
            step();
        end
        req_data_valid = '0;
        @(negedge clk);
        chk("post_burst_grant", req_ready, 3'b100);
        chk("post_burst_dvalid", mem_req_data_valid, 1'b0);
        step();

        // Reset in the middle of a port 0 burst
        req_valid = 3'b001;
        req_rw = 3'b001;
        req_addr[0*AB +: AB] = 16'h0080;
        @(negedge clk);
        chk("rstb_grant", req_ready, 3'b001);
        step();
        req_valid = '0;
        req_data_valid = 3'b001;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            chk("rstb_dready", req_data_ready, 3'b001);
            step();
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rstb_in_reset_dvalid", mem_req_data_valid, 1'b0);
        step();
        reset = 1'b0;
        req_valid = 3'b011;
        req_rw = 3'b000;
        @(negedge clk);
        chk("rstb_after_dvalid", mem_req_data_valid, 1'b0);
        chk("rstb_priority", req_ready, 3'b001);
        step();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            reset              = ($urandom_range(0, 99) == 0);
            req_valid          = NP'($urandom);
            req_rw             = NP'($urandom) & NP'($urandom);
            req_addr           = {$urandom, $urandom};
            req_data_valid     = NP'($urandom) | NP'($urandom);
            req_data_bits      = {$urandom, $urandom};
            req_data_mask      = NP'($urandom) == '0 ? '0 : (NP*MB)'($urandom);
            mem_req_ready      = ($urandom_range(0, 3) != 0);
            mem_req_data_ready = ($urandom_range(0, 3) != 0);
            mem_resp_valid     = ($urandom_range(0, 2) == 0);
            mem_resp_tag       = TB'($urandom);
            step();
        end

        reset = 1'b0;
        clear_inputs();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
